// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback versus a 2-entry in-order
// auxiliary result buffer, with WAW squash, starvation forcing and decode hazard flags.
module wb_write_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wr_en,
  input  logic [2:0]  pipe_wr_reg,
  input  logic [15:0] pipe_wr_data,
  input  logic        aux_valid,
  input  logic [2:0]  aux_reg,
  input  logic [15:0] aux_data,
  output logic        aux_ready,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_reg,
  output logic [15:0] rf_wr_data,
  output logic        pipe_stall,
  input  logic [2:0]  rd_reg_a,
  input  logic [2:0]  rd_reg_b,
  output logic        busy_a,
  output logic        busy_b
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [1:0]  live;
  logic [2:0]  ent_reg [2];
  logic [15:0] ent_data [2];
  logic        head;
  logic [1:0]  count;
  logic [3:0]  starve;

  logic head_live, force_g, pipe_g, head_g, pop, push, tail, enq_live;

  always_comb begin
    head_live = (count != 2'd0) && live[head];
    force_g   = head_live && (count == 2'd2 || starve == SMAX);
    pipe_g    = !force_g && pipe_wr_en;
    head_g    = head_live && (force_g || !pipe_wr_en);
    // A dead head leaves without touching the port.
    pop       = (count != 2'd0) && (!live[head] || head_g);
    push      = aux_valid && (count != 2'd2);
    tail      = head ^ count[0];
    enq_live  = !(pipe_g && aux_reg == pipe_wr_reg);
  end

  always_comb begin
    aux_ready  = 1'b0;
    rf_wr_en   = 1'b0;
    rf_wr_reg  = 3'd0;
    rf_wr_data = 16'd0;
    pipe_stall = 1'b0;
    busy_a     = 1'b0;
    busy_b     = 1'b0;
    if (!rst) begin
      aux_ready  = (count != 2'd2);
      pipe_stall = force_g && pipe_wr_en;
      if (head_g) begin
        rf_wr_en   = 1'b1;
        rf_wr_reg  = ent_reg[head];
        rf_wr_data = ent_data[head];
      end else if (pipe_g) begin
        rf_wr_en   = 1'b1;
        rf_wr_reg  = pipe_wr_reg;
        rf_wr_data = pipe_wr_data;
      end
      busy_a = (live[0] && ent_reg[0] == rd_reg_a)
             | (live[1] && ent_reg[1] == rd_reg_a);
      busy_b = (live[0] && ent_reg[0] == rd_reg_b)
             | (live[1] && ent_reg[1] == rd_reg_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live        <= 2'b00;
      ent_reg[0]  <= 3'd0;
      ent_reg[1]  <= 3'd0;
      ent_data[0] <= 16'd0;
      ent_data[1] <= 16'd0;
      head        <= 1'b0;
      count       <= 2'd0;
      starve      <= 4'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pipe_g && live[i] && ent_reg[i] == pipe_wr_reg)
          live[i] <= 1'b0;
      end
      if (pop)
        live[head] <= 1'b0;
      if (push) begin
        live[tail]     <= enq_live;
        ent_reg[tail]  <= aux_reg;
        ent_data[tail] <= aux_data;
      end
      if (pop)
        head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (head_g || live == 2'b00)
        starve <= 4'd0;
      else if (head_live && starve != SMAX)
        starve <= starve + 4'd1;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected register-file writes are queued
// by the stimulus and a negedge monitor compares every write the DUT issues.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wr_en;
  logic [2:0]  pipe_wr_reg;
  logic [15:0] pipe_wr_data;
  logic        aux_valid;
  logic [2:0]  aux_reg;
  logic [15:0] aux_data;
  logic        aux_ready;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_reg;
  logic [15:0] rf_wr_data;
  logic        pipe_stall;
  logic [2:0]  rd_reg_a;
  logic [2:0]  rd_reg_b;
  logic        busy_a;
  logic        busy_b;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d;
    logic        s;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  wb_write_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_reg(pipe_wr_reg),
    .pipe_wr_data(pipe_wr_data),
    .aux_valid(aux_valid), .aux_reg(aux_reg), .aux_data(aux_data),
    .aux_ready(aux_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .pipe_stall(pipe_stall),
    .rd_reg_a(rd_reg_a), .rd_reg_b(rd_reg_b),
    .busy_a(busy_a), .busy_b(busy_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_wr_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL write_unexpected: got r%0d=%h stall=%0b, none required",
                 rf_wr_reg, rf_wr_data, pipe_stall);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_wr_reg !== e.r || rf_wr_data !== e.d || pipe_stall !== e.s) begin
          n_bad++;
          $display("FAIL write_match: got r%0d=%h stall=%0b, required r%0d=%h stall=%0b",
                   rf_wr_reg, rf_wr_data, pipe_stall, e.r, e.d, e.s);
        end
      end
    end
  end

  task automatic check(input string name, input logic got, input logic req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  task automatic drive(input logic pe, input logic [2:0] pr, input logic [15:0] pd,
                       input logic av, input logic [2:0] ar, input logic [15:0] ad);
    pipe_wr_en = pe; pipe_wr_reg = pr; pipe_wr_data = pd;
    aux_valid = av; aux_reg = ar; aux_data = ad;
  endtask

  task automatic expect_wr(input logic [2:0] r, input logic [15:0] d, input logic s);
    wr_t e;
    e.r = r; e.d = d; e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rd_reg_a = 3'd0;
    rd_reg_b = 3'd0;
    drive(1'b1, 3'd3, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
    #2;
    check("reset_wr_en", rf_wr_en, 1'b0);
    check("reset_aux_ready", aux_ready, 1'b0);
    check("reset_stall", pipe_stall, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    step(); step();
    rst = 1'b0;
    #1;

    // 1: pipe write on idle buffer
    drive(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0);
    expect_wr(3'd3, 16'hBEEF, 1'b0);
    #1;
    check("t1_aux_ready", aux_ready, 1'b1);
    step();

    // 2: aux enqueue, written next cycle
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h1234);
    rd_reg_a = 3'd5;
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    expect_wr(3'd5, 16'h1234, 1'b0);
    #1;
    check("t2_busy_pending", busy_a, 1'b1);
    step();
    check("t2_busy_clear", busy_a, 1'b0);
    check("t2_ready", aux_ready, 1'b1);

    // 3: full-buffer force, then starvation force
    drive(1'b1, 3'd7, 16'h0001, 1'b1, 3'd1, 16'h00A1);
    expect_wr(3'd7, 16'h0001, 1'b0);
    step();
    drive(1'b1, 3'd7, 16'h0002, 1'b1, 3'd2, 16'h00A2);
    expect_wr(3'd7, 16'h0002, 1'b0);
    step();
    drive(1'b1, 3'd7, 16'h0003, 1'b0, 3'd0, 16'h0);
    expect_wr(3'd1, 16'h00A1, 1'b1);
    #1;
    check("t3_ready_full", aux_ready, 1'b0);
    check("t3_stall_force", pipe_stall, 1'b1);
    step();
    expect_wr(3'd7, 16'h0003, 1'b0);
    #1;
    check("t3_stall_release", pipe_stall, 1'b0);
    step();
    for (int i = 4; i <= 6; i++) begin
      drive(1'b1, 3'd7, 16'(i), 1'b0, 3'd0, 16'h0);
      expect_wr(3'd7, 16'(i), 1'b0);
      step();
    end
    drive(1'b1, 3'd7, 16'h0007, 1'b0, 3'd0, 16'h0);
    expect_wr(3'd2, 16'h00A2, 1'b1);
    step();
    expect_wr(3'd7, 16'h0007, 1'b0);
    step();

    // 4: buffered r6 squashed by younger pipe write
    rd_reg_b = 3'd6;
    drive(1'b1, 3'd0, 16'h1111, 1'b1, 3'd6, 16'h0666);
    expect_wr(3'd0, 16'h1111, 1'b0);
    step();
    drive(1'b1, 3'd6, 16'h0007, 1'b0, 3'd0, 16'h0);
    expect_wr(3'd6, 16'h0007, 1'b0);
    #1;
    check("t4_busy_before", busy_b, 1'b1);
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    #1;
    check("t4_busy_squashed", busy_b, 1'b0);
    step();
    step();

    // 5: same-cycle enqueue squashed on entry
    rd_reg_a = 3'd4;
    drive(1'b1, 3'd4, 16'h0044, 1'b1, 3'd4, 16'h0400);
    expect_wr(3'd4, 16'h0044, 1'b0);
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    #1;
    check("t5_busy_dead", busy_a, 1'b0);
    check("t5_ready", aux_ready, 1'b1);
    step();
    step();

    // 6: reset with a full buffer
    rd_reg_a = 3'd1;
    drive(1'b1, 3'd7, 16'h0101, 1'b1, 3'd1, 16'h0B01);
    expect_wr(3'd7, 16'h0101, 1'b0);
    step();
    drive(1'b1, 3'd7, 16'h0102, 1'b1, 3'd2, 16'h0B02);
    expect_wr(3'd7, 16'h0102, 1'b0);
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    rst = 1'b1;
    #1;
    check("t6_rst_wr_en", rf_wr_en, 1'b0);
    check("t6_rst_ready", aux_ready, 1'b0);
    check("t6_rst_busy", busy_a, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("t6_ready_after", aux_ready, 1'b1);
    check("t6_busy_after", busy_a, 1'b0);
    repeat (4) step();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL writes_missing: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback and an auxiliary long-latency result path, such as a multi-cycle unit or a memory fill return.
- Auxiliary results are held in a 2-entry in-order buffer and granted the port when the pipeline is idle, when the buffer is full, or when an entry has waited too long.
- WAW ordering is enforced: the pipeline write is always the younger one.
- Sits between writeback and the register file; also reports pending-write hazards to decode.

Parameters:
- STARVE_MAX, 4: consecutive cycles a live buffer head may be denied before it is forced through (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pipe_wr_en  in  1  pipeline writeback requests a write this cycle
- pipe_wr_reg  in  3  pipeline destination register
- pipe_wr_data  in  16  pipeline write data
- aux_valid  in  1  auxiliary result offered
- aux_reg  in  3  auxiliary destination register
- aux_data  in  16  auxiliary write data
- aux_ready  out  1  buffer can accept; transfer occurs on aux_valid & aux_ready at the rising edge
- rf_wr_en  out  1  register-file write enable
- rf_wr_reg  out  3  register-file write select
- rf_wr_data  out  16  register-file write data
- pipe_stall  out  1  pipeline write not granted this cycle; pipeline must hold its WB request
- rd_reg_a  in  3  decode source register A
- rd_reg_b  in  3  decode source register B
- busy_a  out  1  live buffered write pending to rd_reg_a
- busy_b  out  1  live buffered write pending to rd_reg_b

Behaviour:
State and reset:
- State: 2 entries {live, reg, data}, head pointer, count (0..2), starve counter (4 bits).
- rst asserted: count=0, all live=0, starve=0, immediately and asynchronously.
- While rst is high, outputs are forced: aux_ready=0, rf_wr_en=0, rf_wr_reg=0, rf_wr_data=0, pipe_stall=0, busy_a=busy_b=0.
- Reset mid-operation discards buffered entries with no write.

Output timing:
- aux_ready = (count<2), from registered count only; no same-cycle bypass.
- rf_* outputs are combinational from the current state and pipe inputs; the register file writes at the next edge.

Dead head handling:
- If count>0 and the head is dead, it is popped this cycle without using the port.
- For this cycle's arbitration, the buffer is treated as empty.

Arbitration (evaluated in this order, using the live head):
- Force: count==2, or starve==STARVE_MAX, and the head is live. The head is granted: rf_* = head, pop. pipe_stall = pipe_wr_en.
- Pipe: otherwise, if pipe_wr_en. The pipe is granted: rf_* = pipe, pipe_stall=0.
- Aux: otherwise, if the head is live. The head is granted and popped.
- Idle: otherwise rf_wr_en=0, with rf_wr_reg=0 and rf_wr_data=0.

WAW squash (applies when the pipe is granted):
- Every buffered live entry with reg==pipe_wr_reg is cleared to dead.
- An entry enqueued in the same cycle with aux_reg==pipe_wr_reg is stored dead. Auxiliary results are older than any concurrent pipeline write.

Starvation counter:
- starve resets to 0 when the buffer holds no live entry, or when the head is granted.
- It increments when a live head is denied, saturating at STARVE_MAX.

Buffer update:
- Enqueue and pop may happen in the same cycle; count is unchanged in that case.
- Pointers wrap modulo 2.
- Minimum latency: an entry enqueued at edge N can be written at the edge N+1.

Busy flags:
- busy_x = OR over live entries of (reg==rd_reg_x).
- A same-cycle enqueue does not set busy; it is visible the next cycle.

Test Plan:
1. Idle buffer; pipe_wr_en=1, reg=3, data=16'hBEEF → same cycle rf_wr_en=1, rf_wr_reg=3, rf_wr_data=16'hBEEF, pipe_stall=0, aux_ready=1.
2. Aux enqueue reg=5, data=16'h1234 with pipe idle → next cycle rf write to r5 with 16'h1234; then count=0 and busy_a=0 for rd_reg_a=5.
3. Two aux enqueues (reg 1, reg 2) while pipe writes continuously:
   - aux_ready drops to 0.
   - The next cycle is forced: r1 written, pipe_stall=1.
   - The cycle after: count=1, so the pipe is granted (stall=0).
   - r2 is forced after 4 denials (STARVE_MAX=4).
4. Aux reg=6 buffered, then pipe writes r6=16'h0007 → pipe granted, entry dead, busy on r6=0, r6 ends at 16'h0007 with no later aux write.
5. Same-cycle aux enqueue reg=4 and pipe write r4 → pipe granted; aux entry dead; no aux write to r4 ever issued.
6. Assert rst with count=2 mid-stream → outputs 0 immediately; after release count=0, aux_ready=1, no stale writes.
